// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: job control, weight/activation handshakes and PE-array outputs
// for systolic_feeder.
//   start, num_vec          job request and its activation-vector count
//   w_valid/w_ready/w_data  weight-word stream, row-major order
//   a_valid/a_ready/a_data  activation-vector stream, element r at [r*DATA_WIDTH +: DATA_WIDTH]
//   load_weight, weight_bus weight-commit strobe and per-PE weights (PE(r,c) = element r*N+c)
//   act_out                 skewed left-edge activations, element r drives array row r
//   busy, done              job in progress / job-complete pulse
// The master modport belongs to the job source; the slave modport belongs to the feeder.
interface systolic_feeder_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N          = 4,
    parameter int unsigned CNT_WIDTH  = 8
);
    logic                         start;
    logic [CNT_WIDTH-1:0]         num_vec;
    logic                         w_valid;
    logic                         w_ready;
    logic [DATA_WIDTH-1:0]        w_data;
    logic                         a_valid;
    logic                         a_ready;
    logic [N*DATA_WIDTH-1:0]      a_data;
    logic                         load_weight;
    logic [N*N*DATA_WIDTH-1:0]    weight_bus;
    logic [N*DATA_WIDTH-1:0]      act_out;
    logic                         busy;
    logic                         done;

    modport master (
        output start, num_vec, w_valid, w_data, a_valid, a_data,
        input  w_ready, a_ready, load_weight, weight_bus, act_out, busy, done
    );

    modport slave (
        input  start, num_vec, w_valid, w_data, a_valid, a_data,
        output w_ready, a_ready, load_weight, weight_bus, act_out, busy, done
    );
endinterface

// File: rtl/systolic_feeder.sv
// systolic_feeder: loads an N x N weight set into a PE array, commits it with a one-cycle
// strobe, then streams num_vec activation vectors through a skew network so that row r
// receives its element r cycles after row 0. A drain phase flushes the skew and the array
// before a done pulse.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    systolic_feeder_if.slave (see the interface file for the signal list)
module systolic_feeder #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N          = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input logic              clk,
    input logic              reset,
    systolic_feeder_if.slave bus
);

    localparam int unsigned NumW   = N * N;
    localparam int unsigned IdxW   = (NumW > 1) ? $clog2(NumW) : 1;
    localparam int unsigned DrainW = $clog2(2 * N);
    localparam logic [IdxW-1:0]   LastIdx   = IdxW'(NumW - 1);
    localparam logic [DrainW-1:0] LastDrain = DrainW'(2 * N - 2);

    typedef enum logic [2:0] {
        StIdle,
        StWload,
        StWcommit,
        StStream,
        StDrain,
        StDone
    } state_e;

    state_e                      state_q, state_d;
    logic [IdxW-1:0]             idx_q, idx_d;
    logic [CNT_WIDTH-1:0]        vec_cnt_q, vec_cnt_d;
    logic [CNT_WIDTH-1:0]        num_q, num_d;
    logic [DrainW-1:0]           drain_q, drain_d;
    logic [NumW*DATA_WIDTH-1:0]  weight_q;
    logic [N*DATA_WIDTH-1:0]     inj_vec;
    logic [N*DATA_WIDTH-1:0]     act_out;

    logic w_fire, a_fire;
    logic w_ready, a_ready, load_weight, done;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        vec_cnt_d   = vec_cnt_q;
        num_d       = num_q;
        drain_d     = '0;
        w_ready     = 1'b0;
        a_ready     = 1'b0;
        load_weight = 1'b0;
        done        = 1'b0;
        w_fire      = 1'b0;
        a_fire      = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    num_d     = bus.num_vec;
                    vec_cnt_d = '0;
                    idx_d     = '0;
                    state_d   = StWload;
                end
            end
            StWload: begin
                w_ready = 1'b1;
                if (bus.w_valid) begin
                    w_fire = 1'b1;
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StWcommit;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StWcommit: begin
                load_weight = 1'b1;
                state_d     = (num_q != '0) ? StStream : StDrain;
            end
            StStream: begin
                a_ready = 1'b1;
                if (bus.a_valid) begin
                    a_fire    = 1'b1;
                    vec_cnt_d = vec_cnt_q + 1'b1;
                    // This beat is the last vector of the job.
                    if (vec_cnt_q == num_q - 1'b1) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (drain_q == LastDrain) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            vec_cnt_q <= '0;
            num_q     <= '0;
            drain_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            vec_cnt_q <= vec_cnt_d;
            num_q     <= num_d;
            drain_q   <= drain_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            weight_q <= '0;
        end else if (w_fire) begin
            weight_q[idx_q*DATA_WIDTH +: DATA_WIDTH] <= bus.w_data;
        end
    end

    // Anything other than an accepted vector enters the skew network as a zero bubble.
    assign inj_vec = a_fire ? bus.a_data : '0;

    // Row r is a shift line of r+1 stages; stage 0 takes the new element and the oldest
    // stage (index r) drives the array row.
    for (genvar r = 0; r < N; r++) begin : g_row
        logic [(r+1)*DATA_WIDTH-1:0] pipe_q, pipe_d;

        always_comb begin
            pipe_d                   = pipe_q << DATA_WIDTH;
            pipe_d[DATA_WIDTH-1:0]   = inj_vec[r*DATA_WIDTH +: DATA_WIDTH];
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign act_out[r*DATA_WIDTH +: DATA_WIDTH] = pipe_q[r*DATA_WIDTH +: DATA_WIDTH];
    end

    assign bus.w_ready     = w_ready;
    assign bus.a_ready     = a_ready;
    assign bus.load_weight = load_weight;
    assign bus.done        = done;
    assign bus.busy        = (state_q != StIdle);
    assign bus.weight_bus  = weight_q;
    assign bus.act_out     = act_out;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=4, 16-bit data): weight load with and without
// stalls, empty job, skewed streaming back-to-back and with bubbles, and mid-stream reset.
module tb_systolic_feeder;

    localparam int unsigned DW = 16;
    localparam int unsigned N  = 4;
    localparam int unsigned CW = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [255:0] exp_w;

    systolic_feeder_if #(.DATA_WIDTH(DW), .N(N), .CNT_WIDTH(CW)) bus_if ();

    systolic_feeder #(.DATA_WIDTH(DW), .N(N), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while idle; returns at the negedge of the first WLOAD cycle.
    task automatic start_job(input logic [CW-1:0] nv);
        bus_if.start   = 1'b1;
        bus_if.num_vec = nv;
        @(posedge clk); #1;
        bus_if.start   = 1'b0;
        bus_if.num_vec = '0;
        @(negedge clk);
        check_eq("start_busy", bus_if.busy, 1);
        check_eq("start_wready", bus_if.w_ready, 1);
    endtask

    // Sixteen weights base+1..base+16; with stall, two idle cycles precede every beat but
    // the first. Returns at the negedge of the WCOMMIT cycle.
    task automatic wload(input logic [DW-1:0] base, input bit stall);
        for (int i = 0; i < 16; i++) begin
            if (stall && i > 0) begin
                for (int g = 0; g < 2; g++) begin
                    bus_if.w_valid = 1'b0;
                    bus_if.w_data  = 16'hDEAD;
                    @(posedge clk); @(negedge clk);
                    check_eq($sformatf("gap_wbus_%0d", i), bus_if.weight_bus, exp_w);
                    check_eq($sformatf("gap_lw_%0d", i), bus_if.load_weight, 0);
                    check_eq($sformatf("gap_wready_%0d", i), bus_if.w_ready, 1);
                end
            end
            bus_if.w_valid = 1'b1;
            bus_if.w_data  = base + DW'(i + 1);
            @(posedge clk); #1;
            exp_w[i*DW +: DW] = base + DW'(i + 1);
            bus_if.w_valid = 1'b0;
            @(negedge clk);
            check_eq($sformatf("wbus_%0d", i), bus_if.weight_bus, exp_w);
            check_eq($sformatf("lw_%0d", i), bus_if.load_weight, (i == 15) ? 1 : 0);
        end
    endtask

    // Called at the WCOMMIT negedge. v1 is offered from the first edge (accepted at edge a1),
    // v2 is offered only at edge a2 (a2 == 0: single-vector job). Trace index k is sampled
    // after edge k+1.
    task automatic stream(input logic [63:0] v1, input logic [63:0] v2, input int a1,
                          input int a2);
        int         last;
        int         j;
        logic [63:0] e;
        last = (a2 != 0) ? a2 : a1;
        for (int k = 0; k < last + 8; k++) begin
            j = k + 1;
            if (j <= a1) begin
                bus_if.a_valid = 1'b1;
                bus_if.a_data  = v1;
            end else if (j == a2) begin
                bus_if.a_valid = 1'b1;
                bus_if.a_data  = v2;
            end else begin
                bus_if.a_valid = 1'b0;
                bus_if.a_data  = 64'hBAD0_BAD0_BAD0_BAD0;
            end
            @(posedge clk); #1;
            bus_if.a_valid = 1'b0;
            @(negedge clk);
            e = '0;
            for (int r = 0; r < int'(N); r++) begin
                if (k == a1 - 1 + r) e[r*DW +: DW] = v1[r*DW +: DW];
                else if (a2 != 0 && k == a2 - 1 + r) e[r*DW +: DW] = v2[r*DW +: DW];
            end
            check_eq($sformatf("act_k%0d", k), bus_if.act_out, e);
            check_eq($sformatf("aready_k%0d", k), bus_if.a_ready, (k <= last - 2) ? 1 : 0);
            check_eq($sformatf("done_k%0d", k), bus_if.done, (k == last + 6) ? 1 : 0);
            check_eq($sformatf("busy_k%0d", k), bus_if.busy, (k <= last + 6) ? 1 : 0);
            check_eq($sformatf("lw_k%0d", k), bus_if.load_weight, 0);
            check_eq($sformatf("wstable_k%0d", k), bus_if.weight_bus, exp_w);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, bus_if.busy, 0);
        check_eq({tag, "_done"}, bus_if.done, 0);
        check_eq({tag, "_wready"}, bus_if.w_ready, 0);
        check_eq({tag, "_aready"}, bus_if.a_ready, 0);
        check_eq({tag, "_lw"}, bus_if.load_weight, 0);
        check_eq({tag, "_wbus"}, bus_if.weight_bus, 0);
        check_eq({tag, "_act"}, bus_if.act_out, 0);
    endtask

    int done_cnt;

    initial begin
        reset          = 1'b1;
        bus_if.start   = 1'b0;
        bus_if.num_vec = '0;
        bus_if.w_valid = 1'b0;
        bus_if.w_data  = '0;
        bus_if.a_valid = 1'b0;
        bus_if.a_data  = '0;
        exp_w          = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst");
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("idle");

        // Empty job with continuous weights 1..16; a_valid held high must not be taken.
        start_job(8'd0);
        wload(16'd0, 1'b0);
        check_eq("w_elem5", bus_if.weight_bus[5*DW +: DW], 16'd6);
        check_eq("w_elem15", bus_if.weight_bus[15*DW +: DW], 16'd16);
        bus_if.a_valid = 1'b1;
        bus_if.a_data  = 64'h1111_2222_3333_4444;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); @(negedge clk);
            check_eq($sformatf("empty_aready_%0d", k), bus_if.a_ready, 0);
            check_eq($sformatf("empty_done_%0d", k), bus_if.done, (k == 7) ? 1 : 0);
            check_eq($sformatf("empty_busy_%0d", k), bus_if.busy, (k <= 7) ? 1 : 0);
            check_eq($sformatf("empty_act_%0d", k), bus_if.act_out, 0);
        end
        bus_if.a_valid = 1'b0;

        // Stalled weight load, then two vectors back-to-back.
        start_job(8'd2);
        wload(16'h0100, 1'b1);
        stream(64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, 2, 3);

        // Two vectors separated by two bubble cycles; full-width values pass untouched.
        start_job(8'd2);
        wload(16'h0200, 1'b0);
        stream(64'h0028_001E_0014_000A, 64'h8001_FFFF_7FFF_0050, 2, 5);

        // Reset in the middle of streaming.
        start_job(8'd5);
        wload(16'h0300, 1'b0);
        bus_if.a_valid = 1'b1;
        bus_if.a_data  = 64'h0004_0003_0002_0001;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midrst");
        bus_if.a_valid = 1'b0;
        exp_w = '0;
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); @(negedge clk);
            if (bus_if.done === 1'b1) done_cnt++;
        end
        check_eq("postrst_no_done", done_cnt, 0);
        check_eq("postrst_busy", bus_if.busy, 0);

        // Fresh single-vector job after reset.
        start_job(8'd1);
        wload(16'h0400, 1'b0);
        stream(64'hA5A5_0F0F_1234_CAFE, 64'h0, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, which is the bit width of each weight and activation.
REQ-002 The block SHALL have parameter N, default 4, which is the array dimension (N rows x N columns of PEs).
REQ-003 The block SHALL have parameter CNT_WIDTH, default 8, which is the width of the vector count.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  begin a weight-load plus stream job; honoured in IDLE only.
REQ-007 num_vec  input  CNT_WIDTH  count of activation vectors for the job; sampled when start is honoured.
REQ-008 w_valid / w_ready  input / output  1 each  weight-word handshake.
REQ-009 w_data  input  DATA_WIDTH  weight word.
REQ-010 a_valid / a_ready  input / output  1 each  activation-vector handshake.
REQ-011 a_data  input  N*DATA_WIDTH  activation vector; element r occupies bits [r*DATA_WIDTH +: DATA_WIDTH].
REQ-012 load_weight  output  1  one-cycle weight-commit strobe to the PE array.
REQ-013 weight_bus  output  N*N*DATA_WIDTH  per-PE weights; PE(r,c) is element r*N+c.
REQ-014 act_out  output  N*DATA_WIDTH  skewed left-edge inputs; element r drives row r.
REQ-015 busy, done  output  1 each  busy: job in progress; done: job-complete pulse.

Function
REQ-016 The block SHALL implement states IDLE, WLOAD, WCOMMIT, STREAM, DRAIN and DONE.
REQ-017 IDLE: w_ready, a_ready, load_weight and busy SHALL be 0; start=1 SHALL latch num_vec and move to WLOAD.
REQ-018 busy SHALL be 1 in every state except IDLE, and start SHALL be ignored while busy is 1.
REQ-019 WLOAD: w_ready SHALL be 1; each w_valid&&w_ready beat SHALL write w_data to weight_bus element idx, then increment idx (0..N*N-1, row-major).
REQ-020 idx SHALL advance only on a handshake; gaps in w_valid SHALL stall without side effects.
REQ-021 On the (N*N)th beat the next state SHALL be WCOMMIT, and idx SHALL clear to 0.
REQ-022 weight_bus SHALL change only on WLOAD handshakes and SHALL hold stable through WCOMMIT, STREAM and DRAIN.
REQ-023 WCOMMIT SHALL last exactly one cycle with load_weight=1; next state SHALL be STREAM if the latched count is nonzero, else DRAIN.
REQ-024 STREAM: a_ready SHALL be 1; each a_valid&&a_ready beat SHALL inject a_data into the skew network and increment the vector counter.
REQ-025 In any STREAM cycle without a handshake, and in every DRAIN cycle, the block SHALL inject an all-zero vector (bubble).
REQ-026 Skew: for a vector accepted at edge t, element r SHALL appear on act_out row r for exactly the cycle following edge t+r (latency r+1 register stages, row 0 = 1 stage).
REQ-027 When the counter reaches the latched num_vec, the beat SHALL be accepted and the next state SHALL be DRAIN, with a_ready=0 from that cycle.
REQ-028 DRAIN SHALL last exactly 2*N-1 cycles (skew flush plus array traversal), then the block SHALL go to DONE.
REQ-029 DONE SHALL last one cycle with done=1, then the block SHALL return to IDLE; done SHALL be 0 in all other states.
REQ-030 Delay-line contents SHALL be pure pass-through; no arithmetic, truncation or sign handling SHALL be applied.

Reset
REQ-031 reset=1 SHALL immediately force state IDLE, clear idx and the vector counter to 0, and zero weight_bus, act_out and all delay registers.
REQ-032 While reset=1, load_weight, busy, done, w_ready and a_ready SHALL all be 0.
REQ-033 Reset asserted mid-job SHALL abandon the job with no done pulse; a later start SHALL behave as from power-up.

Verification
REQ-034 Reset test: assert reset at an arbitrary mid-STREAM point -> all outputs 0 asynchronously, before the next clock edge.
REQ-035 Weight load test: N=4, w_data=1..16 with continuous w_valid -> load_weight high for exactly the one cycle after the 16th beat, element 5 = 6, element 15 = 16.
REQ-036 Stall test: w_valid toggles 1,0,0,1,... -> weight_bus writes occur only on handshake cycles, and load_weight still follows the 16th accepted beat.
REQ-037 Skew test: num_vec=2, vectors {1,2,3,4} then {5,6,7,8} back-to-back -> row 0 shows 1,5 at t+1,t+2; row 3 shows 4,8 at t+4,t+5; zeros elsewhere.
REQ-038 Bubble test: a_valid low for 2 cycles between vectors -> 2 zero cycles per row, shifted by row index.
REQ-039 Empty job test: num_vec=0 -> WLOAD, then WCOMMIT, then 7 DRAIN cycles, done pulse, no a_ready assertion.
